// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decode arbiter: state encoding,
// requester count and the reset value of the round-robin pointer.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Pointer starts at the last client so client 0 wins first after reset
    localparam logic [IDX_W-1:0] LAST_IDX_RST = 2'd3;

endpackage

// File: rtl/onehot_dec2.sv
// Enabled 2-to-4 one-hot decoder; all-zero output while disabled.
module onehot_dec2
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] dec_c
);

    always_comb begin
        dec_c = '0;
        if (en) begin
            dec_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Four-client round-robin arbiter with hold limit and a guaranteed dead cycle
// between owners; the one-hot grant is registered from the decoded next index.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             owner_release,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d;
    logic             timeout_d;
    logic [N_REQ-1:0] grant_d;
    logic [IDX_W-1:0] winner;

    // Rotate so the search starts after the last owner, pick lowest, rotate back
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] start;
        logic [6:0]       dbl;
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] off;
        start = last + 2'd1;
        dbl   = {r[2:0], r};
        rot   = dbl[start +: 4];
        off   = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) begin
                off = 2'(i);
            end
        end
        return start + off;
    endfunction

    assign winner = rr_pick(req, last_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = grant_idx;
        last_d    = last_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d = ST_GRANT;
                    idx_d   = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // A release wins over a simultaneous hold-limit hit
                if (owner_release || !req[grant_idx]) begin
                    state_d = ST_GAP;
                end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    onehot_dec2 u_dec (
        .idx   (idx_d),
        .en    (valid_d),
        .dec_c (grant_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            cnt_q       <= '0;
            last_q      <= LAST_IDX_RST;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
            timeout     <= timeout_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// cycle by cycle against an owner/tenure reference model.
module tb_rr_decode_arbiter;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 none), cycles owned, pointer, dead cycle pending
    int m_owner, m_tenure, m_last, m_cool;
    bit m_timeout;

    logic [3:0] seq[$];
    int         lens[$];
    int         gaps[$];
    logic [3:0] prev;
    int         zrun, run, n_to;
    logic [3:0] exp_rot[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_alt[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    rr_decode_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .owner_release (rel),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_owner   = -1;
        m_tenure  = 0;
        m_last    = 3;
        m_cool    = 0;
        m_timeout = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic rl);
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (rl || !r[m_owner]) begin
                m_owner = -1;
                m_cool  = 1;
            end else if (MAXH != 0 && m_tenure == MAXH) begin
                m_owner   = -1;
                m_cool    = 1;
                m_timeout = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (r[c]) begin
                    m_owner  = c;
                    m_last   = c;
                    m_tenure = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic check_model();
        chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        if (m_owner >= 0) chk("grant_idx", 32'(grant_idx), 32'(m_owner));
        chk("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    task automatic step(input logic [3:0] r, input logic rl);
        req = r;
        rel = rl;
        @(posedge clk);
        model_edge(r, rl);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
    endtask

    task automatic clear_trace();
        seq.delete();
        lens.delete();
        gaps.delete();
        prev = 4'b0000;
        zrun = 0;
        run  = 0;
        n_to = 0;
    endtask

    // Record grant starts, tenure lengths, dead-cycle runs and timeout pulses
    task automatic trace();
        if (timeout) n_to++;
        if (grant != 4'b0000 && prev == 4'b0000) begin
            seq.push_back(grant);
            if (seq.size() > 1) gaps.push_back(zrun);
        end
        if (grant == 4'b0000 && prev != 4'b0000) lens.push_back(run);
        if (grant == 4'b0000) begin
            zrun++;
            run = 0;
        end else begin
            zrun = 0;
            run++;
        end
        prev = grant;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;
        m_reset();

        // Two clients, client 0 releases, client 2 runs to the hold limit
        do_reset();
        clear_trace();
        for (int n = 0; n < 80 && seq.size() < 4; n++) begin
            step(4'b0101, (m_owner == 0));
            trace();
        end
        chk("alt_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size() && i < 4; i++) chk("alt_seq", 32'(seq[i]), 32'(exp_alt[i]));
        for (int i = 0; i < gaps.size(); i++) chk("alt_gap", 32'(gaps[i]), 32'd2);

        // All four requesting, 2-cycle tenures rotate without timeouts
        do_reset();
        clear_trace();
        for (int n = 0; n < 80 && seq.size() < 5; n++) begin
            step(4'b1111, (m_owner >= 0 && m_tenure == 2));
            trace();
        end
        chk("rot_count", 32'(seq.size()), 32'd5);
        for (int i = 0; i < seq.size() && i < 5; i++) chk("rot_seq", 32'(seq[i]), 32'(exp_rot[i]));
        chk("rot_timeouts", 32'(n_to), 32'd0);

        // Single client never releasing: hold limit, timeout, regrant
        do_reset();
        clear_trace();
        for (int n = 0; n < 40; n++) begin
            step(4'b0010, 1'b0);
            trace();
        end
        chk("hold_len", (lens.size() > 0) ? 32'(lens[0]) : 32'hffff, 32'(MAXH));
        chk("hold_gap", (gaps.size() > 0) ? 32'(gaps[0]) : 32'hffff, 32'd2);
        chk("hold_regrant", (seq.size() > 1) ? 32'(seq[1]) : 32'hffff, 32'h2);
        chk("hold_timeouts", 32'(n_to), 32'(lens.size()));

        // Release coincides with the hold-limit cycle: no timeout
        do_reset();
        step(4'b0100, 1'b0);
        for (int n = 0; n < MAXH - 1; n++) step(4'b0100, 1'b0);
        chk("lim_grant_before", 32'(grant), 32'h4);
        step(4'b0100, 1'b1);
        chk("lim_grant_after", 32'(grant), 32'h0);
        chk("lim_timeout", 32'(timeout), 32'h0);

        // Owner 3 drops its request with client 0 pending
        do_reset();
        step(4'b1000, 1'b0);
        chk("drop_owner3", 32'(grant), 32'h8);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0);
        chk("drop_gap", 32'(grant), 32'h0);
        step(4'b1001, 1'b0);
        chk("drop_idle", 32'(grant), 32'h0);
        step(4'b1001, 1'b0);
        chk("drop_regrant", 32'(grant), 32'h1);
        chk("drop_idx", 32'(grant_idx), 32'h0);

        // Asynchronous reset mid-tenure
        do_reset();
        repeat (3) step(4'b1000, 1'b0);
        chk("arst_pre", 32'(grant), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(grant_valid), 32'h0);
        chk("arst_timeout", 32'(timeout), 32'h0);
        req = 4'b1001;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        step(4'b1001, 1'b0);
        chk("arst_first", 32'(grant), 32'h1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r = 4'b0000;
            step(r, ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
